// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1:64 demux/frame collector.
package demux_pkg;

  localparam int unsigned K  = 64;
  localparam int unsigned SW = 6;

  localparam logic [K-1:0] MASK_FULL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/demux_1x64_collect_if.sv
// Beat input and frame output handshake bundle for demux_1x64_collect.
interface demux_1x64_collect_if;

  logic                      in_valid;
  logic                      in_ready;
  logic                      d;
  logic [demux_pkg::SW-1:0]  sel;
  logic [demux_pkg::K-1:0]   y;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_valid, d, sel, out_ready,
    input  in_ready, y, out_valid
  );

  modport slave (
    input  in_valid, d, sel, out_ready,
    output in_ready, y, out_valid
  );

endinterface

// File: rtl/demux_dec_6x64.sv
// One-hot decoder from the 6-bit index to the 64-bit write strobe.
module demux_dec_6x64
  import demux_pkg::*;
(
  input  logic [SW-1:0] sel,
  output logic [K-1:0]  strb
);

  always_comb begin
    strb      = '0;
    strb[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_1x64_collect.sv
// Registered 1:64 demux that assembles a 64-bit frame from indexed bit beats.
// Optional duplicate-index sticky flag `err` when DEMUX_DUP_ERR_EN is defined.
module demux_1x64_collect
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  demux_1x64_collect_if.slave bus,
  output logic [SW:0]       count
`ifdef DEMUX_DUP_ERR_EN
  ,
  output logic              err
`endif
);

  state_t         state, state_nxt;
  logic [K-1:0]   y_q;
  logic [K-1:0]   mask;
  logic [K-1:0]   strb;
  logic           accept;
  logic           is_new;
  logic           handoff;

  demux_dec_6x64 u_dec (
    .sel  (bus.sel),
    .strb (strb)
  );

  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.y         = y_q;

  // clr drops any beat presented alongside it.
  assign accept  = bus.in_valid & bus.in_ready & ~clr;
  assign is_new  = ((mask & strb) == '0);
  assign handoff = (state == HOLD) & bus.out_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ((mask | strb) == MASK_FULL) ? HOLD : COLLECT;
      COLLECT: if (accept && ((mask | strb) == MASK_FULL)) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      mask  <= '0;
      count <= '0;
    end else if (clr || handoff) begin
      mask  <= '0;
      count <= '0;
    end else if (accept) begin
      y_q[bus.sel] <= bus.d;
      mask         <= mask | strb;
      if (is_new) count <= count + (SW+1)'(1);
    end
  end

`ifdef DEMUX_DUP_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (clr || handoff) begin
      err <= 1'b0;
    end else if (accept && !is_new) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x64_collect.sv
// Scoreboard bench for demux_1x64_collect (checks err when DEMUX_DUP_ERR_EN is defined).
module tb_demux_1x64_collect;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [SW:0] count;
`ifdef DEMUX_DUP_ERR_EN
  logic err;
`endif

  demux_1x64_collect_if bus ();

  demux_1x64_collect dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .bus   (bus.slave),
    .count (count)
`ifdef DEMUX_DUP_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [K-1:0] mdl_y;
  logic [K-1:0] mdl_mask;
  int           mdl_cnt;
  logic         mdl_err;
  logic [K-1:0] sb_q[$];

  task automatic mdl_clear();
    mdl_mask = '0;
    mdl_cnt  = 0;
    mdl_err  = 1'b0;
  endtask

  // Drive one beat; checks the effect of the previous beat before driving.
  task automatic send(input logic bd, input logic [SW-1:0] bs);
    @(negedge clk);
    total++;
    if (count !== (SW+1)'(mdl_cnt)) begin
      bad++; $display("FAIL send_count sel=%0d got=%0d exp=%0d", bs, count, mdl_cnt);
    end
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL send_ready got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b1;
    bus.d        = bd;
    bus.sel      = bs;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!mdl_mask[bs]) mdl_cnt++;
    else mdl_err = 1'b1;
    mdl_y[bs]    = bd;
    mdl_mask[bs] = 1'b1;
    if (mdl_mask == MASK_FULL) sb_q.push_back(mdl_y);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.d = 1'b0; bus.sel = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_y = '0; mdl_clear();
    for (int unsigned i = 0; i < 10; i++) send(1'b1, SW'(i * 3));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.y !== '0 || count !== '0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_async y=%h count=%0d out_valid=%b exp 0/0/0", bus.y, count, bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_y = '0; mdl_clear();
    @(negedge clk);
    total++;
    if (bus.y !== '0 || count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_idle y=%h count=%0d ov=%b ir=%b exp 0/0/0/1", bus.y, count, bus.out_valid, bus.in_ready);
    end
`ifdef DEMUX_DUP_ERR_EN
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
  endtask

  task automatic test_seq_fill();
    logic [K-1:0] exp;
    logic [SW-1:0] s;
    for (int unsigned i = 0; i < K; i++) begin
      s = SW'(i);
      send(s[0], s);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || count !== 7'd64) begin
      bad++; $display("FAIL seq_hold ov=%b ir=%b count=%0d exp 1/0/64", bus.out_valid, bus.in_ready, count);
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++; $display("FAIL seq_sb_empty got=0 exp=1 entries");
    end else begin
      exp = sb_q[0];
      if (bus.y !== exp || exp !== 64'hAAAA_AAAA_AAAA_AAAA) begin
        bad++; $display("FAIL seq_y got=%h exp=%h", bus.y, 64'hAAAA_AAAA_AAAA_AAAA);
      end
    end
  endtask

  task automatic test_handoff();
    logic [K-1:0] exp;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : mdl_y;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.sel = 6'd7; bus.d = ~exp[7];
      total++;
      if (bus.y !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_stable cyc=%0d y=%h ov=%b ir=%b exp y=%h 1/0", i, bus.y, bus.out_valid, bus.in_ready, exp);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    mdl_clear();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || count !== '0 || bus.y !== exp) begin
      bad++; $display("FAIL handoff ov=%b ir=%b count=%0d y=%h exp 0/1/0 y=%h", bus.out_valid, bus.in_ready, count, bus.y, exp);
    end
    // First beat of the next frame immediately after the handoff edge.
    bus.in_valid = 1'b1; bus.d = 1'b1; bus.sel = 6'd0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    mdl_y[0] = 1'b1; mdl_mask[0] = 1'b1; mdl_cnt = 1;
    @(negedge clk);
    total++;
    if (count !== 7'd1 || bus.y[0] !== 1'b1) begin
      bad++; $display("FAIL next_first count=%0d y0=%b exp 1/1", count, bus.y[0]);
    end
  endtask

  task automatic finish_frame(input string tag);
    logic [K-1:0] exp;
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    total++;
    if (bus.out_valid !== 1'b1 || sb_q.size() == 0) begin
      bad++; $display("FAIL %s_done ov=%b sb=%0d exp 1/1", tag, bus.out_valid, sb_q.size());
    end else begin
      exp = sb_q.pop_front();
      if (bus.y !== exp || count !== 7'd64) begin
        bad++; $display("FAIL %s_y y=%h count=%0d exp y=%h 64", tag, bus.y, count, exp);
      end
    end
`ifdef DEMUX_DUP_ERR_EN
    total++;
    if (err !== mdl_err) begin bad++; $display("FAIL %s_err got=%b exp=%b", tag, err, mdl_err); end
`endif
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    mdl_clear();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || count !== '0) begin
      bad++; $display("FAIL %s_release ov=%b count=%0d exp 0/0", tag, bus.out_valid, count);
    end
`ifdef DEMUX_DUP_ERR_EN
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL %s_err_clr got=%b exp=0", tag, err); end
`endif
  endtask

  task automatic test_abort();
    logic [SW-1:0] s;
    for (int unsigned i = 1; i < 30; i++) send(1'b1, SW'(i));
    @(negedge clk);
    clr = 1'b1;
    bus.in_valid = 1'b1; bus.sel = 6'd40; bus.d = ~mdl_y[40];
    @(posedge clk);
    #1 clr = 1'b0; bus.in_valid = 1'b0;
    mdl_clear();
    @(negedge clk);
    total++;
    if (count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.y !== mdl_y) begin
      bad++; $display("FAIL abort count=%0d ov=%b ir=%b y=%h exp 0/0/1 y=%h", count, bus.out_valid, bus.in_ready, bus.y, mdl_y);
    end
    for (int unsigned i = 0; i < K; i++) begin
      s = SW'(i);
      if (s != 6'd40) send(~s[1], s);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || count !== 7'd63) begin
      bad++; $display("FAIL abort_63 ov=%b count=%0d exp 0/63", bus.out_valid, count);
    end
    send(1'b0, 6'd40);
    @(negedge clk);
    finish_frame("abort");
  endtask

  task automatic test_random_dup();
    logic [SW-1:0] perm[K];
    logic [SW-1:0] t;
    int j;
    for (int unsigned i = 0; i < K; i++) perm[i] = SW'(i);
    for (int i = K - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    if (perm[K-1] == 6'd5) begin t = perm[0]; perm[0] = perm[K-1]; perm[K-1] = t; end
    for (int unsigned i = 0; i < K; i++) begin
      send(1'($urandom_range(1, 0)), perm[i]);
      if (perm[i] == 6'd5) send(~mdl_y[5], 6'd5);
    end
    @(negedge clk);
    total++;
    if (bus.y[5] !== mdl_y[5]) begin
      bad++; $display("FAIL dup_last_wins got=%b exp=%b", bus.y[5], mdl_y[5]);
    end
    finish_frame("random");
  endtask

  initial begin
    test_reset();
    test_seq_fill();
    test_handoff();
    test_abort();
    test_random_dup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/demux_1x64_collect.md
# demux_1x64_collect

Registered 1:64 demultiplexer and frame collector, the receive-side counterpart of the 64:1 select mux. Each accepted beat carries one data bit and a 6-bit index and writes that bit into the addressed position of a 64-bit frame register. Once every index has been written at least once, the block presents the assembled 64-bit word on a valid/ready output port and holds it until it is taken.

## Interface
Parameters:
- K, 64, frame width (number of demux outputs); fixed at 64 in this revision.
- SW, 6, index width, equal to $clog2(K).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort; drops the partial frame.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat.
- d  input  1  data bit.
- sel  input  SW  destination index, 0..K-1.
- y  output  K  assembled frame register.
- out_valid  output  1  complete frame presented on y.
- out_ready  input  1  consumer takes the frame.
- count  output  SW+1  number of distinct indices written in the current frame, 0..64.
- err  output  1  duplicate-index flag; present only with DEMUX_DUP_ERR_EN.

## Operation
- A beat is accepted on a clock edge when in_valid and in_ready are both 1.
- An accepted beat performs three updates on that edge:
  - y[sel] <= d.
  - mask[sel] <= 1.
  - count increments only if mask[sel] was 0 before the edge.
- States and transitions:
  - IDLE: mask is zero. An accepted beat moves the block to COLLECT.
  - COLLECT: beats keep filling y and mask. The beat that makes the mask all ones moves the block to HOLD, and out_valid rises on that same edge.
  - HOLD: in_ready = 0, out_valid = 1, y is frozen. out_valid and out_ready both 1 on an edge moves the block to IDLE, clears mask and count, and drops out_valid.
- in_ready = 1 in IDLE and COLLECT, 0 in HOLD. in_ready is a combinational function of the state only; it never depends on in_valid.
- Duplicate index within a frame (no macro): the bit is overwritten, last write wins, count is unchanged.
- y is not cleared between frames. Stale bits are harmless, because the frame only completes after all 64 indices have been rewritten.
- clr = 1 on an edge, from any state:
  - Moves the block to IDLE and clears mask, count and out_valid.
  - A beat presented on the same edge is dropped.
  - clr overrides the out_valid/out_ready handoff.
  - y is left unchanged.
- Beats are accepted in any index order; no ordering is implied.

## Timing
- Reset values: state IDLE, y = 0, mask = 0, count = 0, out_valid = 0, err = 0. in_ready = 1 while rst is low.
- Reset is asynchronous. Asserting rst mid-frame or in HOLD discards everything immediately.
- Write latency: y[sel] is visible 1 cycle after the accepting edge.
- Frame latency: out_valid is high in the cycle after the 64th distinct-index accept. With one beat per cycle and no duplicates, that is 64 cycles after the first beat.
- Throughput:
  - Handoff edge: in_ready returns to 1 on the edge where out_valid and out_ready are both 1, but no beat is accepted on that edge.
  - Following cycle: the next frame's first beat can be accepted.
  - Result: one idle cycle between frames.
- out_valid and y stay stable until the handoff edge or clr.

## Configuration
- DEMUX_DUP_ERR_EN defined:
  - Port err exists.
  - err is set on an edge that accepts a beat whose mask[sel] is already 1.
  - err stays set (sticky) until the next handoff, clr, or rst.
  - Data behaviour is otherwise identical to the undefined case.
- DEMUX_DUP_ERR_EN undefined: the err port and its register are absent, and duplicates are silently overwritten.

## Structure
- Package demux_pkg holds:
  - The constants K = 64 and SW = 6.
  - The state enum with IDLE, COLLECT and HOLD.
  - The all-ones mask constant used for completion detection.
- Sub-module demux_dec_6x64: combinational one-hot decoder from sel to a 64-bit write strobe. It is shared by the y write-enable and the mask update.
- Top-level logic: state register, mask, count, output handshake, and the optional err flag.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-frame, then release it.
  - Response: y = 0, count = 0, out_valid = 0, in_ready = 1.
- Sequential fill:
  - Stimulus: beats with sel 0..63, d = sel[0], one per cycle, out_ready = 0.
  - Response: out_valid rises after the 64th beat, y = 64'hAAAA_AAAA_AAAA_AAAA, in_ready = 0 and held.
- Random order with a duplicate:
  - Stimulus: all 64 indices in shuffled order, plus one repeat of sel = 5 carrying the opposite d.
  - Response: count reaches 64 only on the last new index, y[5] holds the later value, and err = 1 with the macro only.
- Handoff:
  - Stimulus: hold out_ready = 0 for 10 cycles in HOLD, then pulse it.
  - Response: y stays stable throughout the hold, and the next frame's first beat is accepted 1 cycle after the handoff.
- Abort:
  - Stimulus: after 30 beats, assert clr together with in_valid.
  - Response: count = 0, state IDLE, and the concurrent beat is not recorded, confirmed by the next frame still needing 64 distinct indices.
